// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM write/read-back sequencer and its bench:
// state encoding, bus widths and the controller control-byte prefix.
package eeprom_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    // Upper nibble of the serial EEPROM control byte (device type 1010)
    localparam logic [3:0] CTRL_PREFIX = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WREQ  = 3'd1,
        S_WWAIT = 3'd2,
        S_WGAP  = 3'd3,
        S_RREQ  = 3'd4,
        S_RWAIT = 3'd5,
        S_RGAP  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/eeprom_wr_seq_if.sv
// Request/acknowledge side of the EEPROM controller port. The tri-state DATA
// pin stays a plain inout on the sequencer so it resolves as an ordinary net.
interface eeprom_wr_seq_if;
    import eeprom_pkg::*;

    logic              WR;
    logic              RD;
    logic [ADDR_W-1:0] ADDR;
    logic              ACK;

    modport master (output WR, output RD, output ADDR, input ACK);
    modport slave  (input WR, input RD, input ADDR, output ACK);

endinterface

// File: rtl/eeprom_wr_seq.sv
// Burst write of SEED+i pattern bytes through the EEPROM controller, then read-back
// and compare. Optional ACK watchdog enabled by defining EEPROM_WR_SEQ_TIMEOUT_EN.
module eeprom_wr_seq
    import eeprom_pkg::*;
#(
    parameter int                NBYTES         = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 11'h000,
    parameter logic [DATA_W-1:0] SEED           = 8'hA5,
    parameter int                GAP_CYCLES     = 16,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [7:0]         err_cnt,
    output logic               timeout,
    eeprom_wr_seq_if.master    bus,
    inout  wire  [DATA_W-1:0]  DATA
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic                start_q;
    logic [7:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          err_q, err_d;
    logic                last;

`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic                timeout_q, timeout_d;
`endif

    assign last = (idx_q == 8'(NBYTES - 1));

    // data_q holds the pattern byte: driven while writing, the compare value while reading
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_q) begin
                    state_d = S_WREQ;
                    idx_d   = 8'd0;
                    addr_d  = BASE_ADDR;
                    data_d  = SEED;
                    oe_d    = 1'b1;
                    wr_d    = 1'b1;
                    err_d   = 8'd0;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            S_WREQ: begin
                state_d = S_WWAIT;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
                cnt_d   = TO_LOAD;
`endif
            end
            S_WWAIT: begin
                if (bus.ACK) begin
                    state_d = S_WGAP;
                    oe_d    = 1'b0;
                    cnt_d   = GAP_LOAD;
                end
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    oe_d      = 1'b0;
                    err_d     = 8'hFF;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            S_WGAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (last) begin
                    state_d = S_RREQ;
                    rd_d    = 1'b1;
                    idx_d   = 8'd0;
                    addr_d  = BASE_ADDR;
                    data_d  = SEED;
                end else begin
                    state_d = S_WREQ;
                    wr_d    = 1'b1;
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + 11'd1;
                    data_d  = data_q + 8'd1;
                    oe_d    = 1'b1;
                end
            end
            S_RREQ: begin
                state_d = S_RWAIT;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
                cnt_d   = TO_LOAD;
`endif
            end
            S_RWAIT: begin
                if (bus.ACK) begin
                    state_d = S_RGAP;
                    if (DATA != data_q) begin
                        err_d = sat_inc8(err_q);
                    end
                end
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
                else if (cnt_q == '0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    err_d     = 8'hFF;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            S_RGAP: begin
                if (last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RREQ;
                    rd_d    = 1'b1;
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + 11'd1;
                    data_d  = data_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            idx_q   <= 8'd0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= SEED;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 8'd0;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            start_q <= start;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.WR   = wr_q;
    assign bus.RD   = rd_q;
    assign bus.ADDR = addr_q;
    assign DATA     = oe_q ? data_q : {DATA_W{1'bz}};
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_q;
`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_wr_seq.sv
// Directed bench: two sequencers (base 0 and base 7FE) against an echoing controller model
// that can corrupt a read, inject a stray ACK, or withhold ACK.
`timescale 1ns/1ps
module tb_eeprom_wr_seq;
    import eeprom_pkg::*;

    localparam int NB  = 4;
    localparam int GAP = 16;
    localparam int TO  = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start, busy_w, done_w, to_w, wr_w, rd_w;
    logic [7:0] err_w [2];
    logic [10:0] addr_w [2];
    logic [7:0] data_rd [2];

    logic [1:0] ack_q, stray, drv_q, corrupt, noack, probe, both_seen;
    logic [7:0] rval [2];
    logic       cur_rd [2];
    int         lat [2];
    int         cyc = 0;
    int         n_req [2];
    int         n_ack [2];
    int         n_done [2];
    int         req_cyc [2][64];
    int         ack_cyc [2][64];
    logic       req_rd [2][64];
    logic [10:0] req_addr [2][64];
    logic [7:0] ack_data [2][64];
    logic [7:0] mem [2][2048];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_data [4] = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};
    logic [10:0] addr_tab0 [4] = '{11'h000, 11'h001, 11'h002, 11'h003};
    logic [10:0] addr_tab1 [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam logic [10:0] BASE = (gi == 1) ? 11'h7FE : 11'h000;
        wire [7:0] data_bus;
        eeprom_wr_seq_if bus_if ();

        eeprom_wr_seq #(
            .NBYTES(NB), .BASE_ADDR(BASE), .SEED(8'hA5),
            .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
        ) u_dut (
            .CLK(clk), .RESET(rst), .start(start[gi]), .busy(busy_w[gi]),
            .done(done_w[gi]), .err_cnt(err_w[gi]), .timeout(to_w[gi]),
            .bus(bus_if), .DATA(data_bus)
        );

        assign wr_w[gi]      = bus_if.WR;
        assign rd_w[gi]      = bus_if.RD;
        assign addr_w[gi]    = bus_if.ADDR;
        assign bus_if.ACK    = ack_q[gi] | stray[gi];
        assign data_bus      = (drv_q[gi] | probe[gi]) ? (probe[gi] ? 8'h5A : rval[gi]) : 8'hzz;
        assign data_rd[gi]   = data_bus;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] slave_rdata(input int s);
        return (corrupt[s] && addr_w[s] == 11'd2) ? 8'h00 : mem[s][addr_w[s]];
    endfunction

    // Controller model: ACK LAT cycles after each WR/RD, echoes written bytes on read
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (wr_w[s] && rd_w[s]) both_seen[s] <= 1'b1;
            if (done_w[s]) n_done[s] <= n_done[s] + 1;
            if (rst) begin
                lat[s]   <= 0;
                ack_q[s] <= 1'b0;
                drv_q[s] <= 1'b0;
            end else if (lat[s] > 1) begin
                lat[s] <= lat[s] - 1;
            end else if (lat[s] == 1) begin
                lat[s] <= 0;
                if (!noack[s]) begin
                    ack_q[s] <= 1'b1;
                    ack_cyc[s][n_ack[s] % 64] <= cyc;
                    n_ack[s] <= n_ack[s] + 1;
                    if (cur_rd[s]) begin
                        drv_q[s] <= 1'b1;
                        rval[s]  <= slave_rdata(s);
                        ack_data[s][n_ack[s] % 64] <= slave_rdata(s);
                        $display("[%0d] dut%0d RD ctrl=%h addr=%h data=%h", cyc, s,
                                 {CTRL_PREFIX, addr_w[s][10:8], 1'b1}, addr_w[s], slave_rdata(s));
                    end else begin
                        mem[s][addr_w[s]] <= data_rd[s];
                        ack_data[s][n_ack[s] % 64] <= data_rd[s];
                        $display("[%0d] dut%0d WR ctrl=%h addr=%h data=%h", cyc, s,
                                 {CTRL_PREFIX, addr_w[s][10:8], 1'b0}, addr_w[s], data_rd[s]);
                    end
                end
            end else begin
                ack_q[s] <= 1'b0;
                drv_q[s] <= 1'b0;
                if (wr_w[s] || rd_w[s]) begin
                    lat[s]    <= LAT;
                    cur_rd[s] <= rd_w[s];
                    req_cyc[s][n_req[s] % 64]  <= cyc;
                    req_rd[s][n_req[s] % 64]   <= rd_w[s];
                    req_addr[s][n_req[s] % 64] <= addr_w[s];
                    n_req[s] <= n_req[s] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int s, output int scyc);
        @(negedge clk);
        start[s] = 1'b1;
        scyc = cyc;
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    task automatic wait_done(input int s, input string tag);
        int k = 0;
        while (!done_w[s] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done_reached"}, {31'd0, done_w[s]}, 32'd1);
    endtask

    task automatic check_burst(input int s, input int r0, input int a0,
                               input logic [10:0] ea [4], input int scyc);
        for (int j = 0; j < 2 * NB; j++) begin
            check($sformatf("d%0d txn%0d op_is_rd", s, j), {31'd0, req_rd[s][r0 + j]}, (j >= NB) ? 32'd1 : 32'd0);
            check($sformatf("d%0d txn%0d addr", s, j), {21'd0, req_addr[s][r0 + j]}, {21'd0, ea[j % NB]});
            if (j < NB)
                check($sformatf("d%0d txn%0d wdata", s, j), {24'd0, ack_data[s][a0 + j]}, {24'd0, exp_data[j]});
        end
        check($sformatf("d%0d start_to_wr", s), req_cyc[s][r0] - scyc, 32'd2);
        check($sformatf("d%0d ack_to_wr", s), req_cyc[s][r0 + 1] - ack_cyc[s][a0], GAP + 1);
        check($sformatf("d%0d lastwr_ack_to_rd", s), req_cyc[s][r0 + NB] - ack_cyc[s][a0 + NB - 1], GAP + 1);
        check($sformatf("d%0d ack_to_rd", s), req_cyc[s][r0 + NB + 1] - ack_cyc[s][a0 + NB], 32'd2);
    endtask

    initial begin
        int scyc, r0, a0, nd, k, wcyc;
        rst = 1'b1; start = 2'b00; stray = 2'b00; corrupt = 2'b00;
        noack = 2'b00; probe = 2'b00; both_seen = 2'b00;
        repeat (3) @(negedge clk);

        // Reset state of both instances, DATA released (probe drives 5A unopposed)
        probe = 2'b11;
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("rst d%0d WR", s), {31'd0, wr_w[s]}, 32'd0);
            check($sformatf("rst d%0d RD", s), {31'd0, rd_w[s]}, 32'd0);
            check($sformatf("rst d%0d busy", s), {31'd0, busy_w[s]}, 32'd0);
            check($sformatf("rst d%0d done", s), {31'd0, done_w[s]}, 32'd0);
            check($sformatf("rst d%0d timeout", s), {31'd0, to_w[s]}, 32'd0);
            check($sformatf("rst d%0d err_cnt", s), {24'd0, err_w[s]}, 32'd0);
            check($sformatf("rst d%0d DATA hiz", s), {24'd0, data_rd[s]}, 32'h5A);
        end
        check("rst d0 ADDR", {21'd0, addr_w[0]}, 32'h000);
        check("rst d1 ADDR", {21'd0, addr_w[1]}, 32'h7FE);
        probe = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // Clean burst on base 0
        r0 = n_req[0]; a0 = n_ack[0]; nd = n_done[0];
        pulse_start(0, scyc);
        check("t1 busy_before_accept", {31'd0, busy_w[0]}, 32'd0);
        @(negedge clk);
        check("t1 WR_first", {31'd0, wr_w[0]}, 32'd1);
        check("t1 busy", {31'd0, busy_w[0]}, 32'd1);
        check("t1 DATA_in_WR", {24'd0, data_rd[0]}, 32'hA5);
        wait_done(0, "t1");
        check("t1 busy_at_done", {31'd0, busy_w[0]}, 32'd0);
        check("t1 err_cnt", {24'd0, err_w[0]}, 32'd0);
        check_burst(0, r0, a0, addr_tab0, scyc);
        repeat (5) @(negedge clk);
        check("t1 done_pulses", n_done[0] - nd, 32'd1);

        // Read of address 2 corrupted
        corrupt[0] = 1'b1;
        pulse_start(0, scyc);
        wait_done(0, "t2");
        check("t2 err_cnt", {24'd0, err_w[0]}, 32'd1);
        corrupt[0] = 1'b0;

        // Address wrap 7FE -> 001
        r0 = n_req[1]; a0 = n_ack[1];
        pulse_start(1, scyc);
        wait_done(1, "t3");
        check("t3 err_cnt", {24'd0, err_w[1]}, 32'd0);
        check_burst(1, r0, a0, addr_tab1, scyc);

        // Reset during the third write's wait
        r0 = n_req[0]; nd = n_done[0];
        pulse_start(0, scyc);
        k = 0;
        while (n_req[0] < r0 + 3 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t4 third_wr_seen", (n_req[0] >= r0 + 3) ? 32'd1 : 32'd0, 32'd1);
        check("t4 ADDR_in_wwait", {21'd0, addr_w[0]}, 32'h002);
        check("t4 DATA_in_wwait", {24'd0, data_rd[0]}, 32'hA7);
        rst = 1'b1;
        @(negedge clk);
        probe[0] = 1'b1;
        #1;
        check("t4 WR_after_rst", {31'd0, wr_w[0]}, 32'd0);
        check("t4 RD_after_rst", {31'd0, rd_w[0]}, 32'd0);
        check("t4 busy_after_rst", {31'd0, busy_w[0]}, 32'd0);
        check("t4 ADDR_after_rst", {21'd0, addr_w[0]}, 32'h000);
        check("t4 DATA_hiz_after_rst", {24'd0, data_rd[0]}, 32'h5A);
        probe[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t4 no_done", n_done[0] - nd, 32'd0);
        check("t4 idle_no_wr", n_req[0] - r0, 32'd3);

        // Second start and a stray ACK, both during the first write gap
        r0 = n_req[0]; a0 = n_ack[0]; nd = n_done[0];
        pulse_start(0, scyc);
        k = 0;
        while (n_ack[0] < a0 + 1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        start[0] = 1'b1; stray[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; stray[0] = 1'b0;
        wait_done(0, "t5");
        check("t5 err_cnt", {24'd0, err_w[0]}, 32'd0);
        check_burst(0, r0, a0, addr_tab0, scyc);
        repeat (40) @(negedge clk);
        check("t5 done_pulses", n_done[0] - nd, 32'd1);
        check("t5 txn_count", n_req[0] - r0, 2 * NB);

`ifdef EEPROM_WR_SEQ_TIMEOUT_EN
        // Controller never answers: watchdog ends the burst
        noack[0] = 1'b1;
        r0 = n_req[0];
        pulse_start(0, scyc);
        k = 0;
        while (n_req[0] < r0 + 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        wcyc = req_cyc[0][r0 % 64];
        wait_done(0, "t6");
        check("t6 done_latency", ((cyc - wcyc) == 33 || (cyc - wcyc) == 34) ? 32'd1 : 32'd0, 32'd1);
        check("t6 timeout", {31'd0, to_w[0]}, 32'd1);
        check("t6 err_cnt", {24'd0, err_w[0]}, 32'hFF);
        noack[0] = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start(0, scyc);
        @(negedge clk);
        check("t6 timeout_cleared", {31'd0, to_w[0]}, 32'd0);
        wait_done(0, "t6b");
        check("t6b err_cnt", {24'd0, err_w[0]}, 32'd0);
`else
        wcyc = 0;
`endif

        check("never_wr_and_rd", {30'd0, both_seen}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
